fig_04a_block_075_prefix_regsel: RTL and testbench

- Decodes the SuperFX register-prefix opcodes (ALT1/2/3, TO, WITH, FROM) and tracks the prefix state across the instruction stream: Sreg, Dreg, the B flag and the ALT1/ALT2 flags.
- Latches the source and destination register indices for each executing instruction.
- Sequences the writeback of the result onto the z / zsel / z_we bus consumed directly by the register-file stage (fig_04b_block_076_registers).
- Sits directly upstream of the register file, between the instruction decode and the register file.

---
 rtl/fig_04a_block_075_prefix_regsel.sv | 118 +++++++++++
 tb/tb_fig_04a_block_075_prefix_regsel.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fig_04a_block_075_prefix_regsel.sv
// fig_04a_block_075_prefix_regsel: SuperFX prefix decode, exec register latch and writeback sequencing
module fig_04a_block_075_prefix_regsel #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [7:0]            opcode,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [3:0]            sreg,
  output logic [3:0]            dreg,
  output logic                  bflag,
  output logic                  alt1,
  output logic                  alt2,
  output logic [3:0]            exec_sreg,
  output logic [3:0]            exec_dreg,
  output logic [1:0]            exec_alt,
  output logic                  exec_move,
  output logic                  exec_strobe,
  output logic [DATA_WIDTH-1:0] z,
  output logic [3:0]            zsel,
  output logic                  z_we,
  output logic                  pc_wr
);
  logic [3:0] hi, n;
  logic [3:0] sreg_q, sreg_d, dreg_q, dreg_d, exec_sreg_q, exec_sreg_d, exec_dreg_q, exec_dreg_d;
  logic [3:0] zsel_q, zsel_d;
  logic [1:0] alt_q, alt_d, exec_alt_q, exec_alt_d;
  logic bflag_q, bflag_d, exec_move_q, exec_move_d, exec_strobe_q, exec_strobe_d;
  logic z_we_q, z_we_d, pc_wr_q, pc_wr_d;
  logic [DATA_WIDTH-1:0] z_q, z_d;
  assign hi = opcode[7:4];
  assign n  = opcode[3:0];
  always_comb begin
    sreg_d        = sreg_q;
    dreg_d        = dreg_q;
    bflag_d       = bflag_q;
    alt_d         = alt_q;
    exec_sreg_d   = exec_sreg_q;
    exec_dreg_d   = exec_dreg_q;
    exec_alt_d    = exec_alt_q;
    exec_move_d   = exec_move_q;
    exec_strobe_d = 1'b0;
    // writeback retires the instruction already latched, so it reads the pre-update exec_dreg
    z_we_d        = wb_valid;
    pc_wr_d       = wb_valid && exec_dreg_q == 4'hf;
    z_d           = wb_valid ? wb_data : z_q;
    zsel_d        = wb_valid ? exec_dreg_q : zsel_q;
    if (op_valid) begin
      if (opcode inside {8'h3d, 8'h3e, 8'h3f}) alt_d = opcode[1:0];
      else if (hi == 4'h2) begin
        sreg_d  = n;
        dreg_d  = n;
        bflag_d = 1'b1;
      end
      else if (hi == 4'h1 && !bflag_q) dreg_d = n;
      else if (hi == 4'hb && !bflag_q) sreg_d = n;
      else begin
        // 0x1n / 0xBn reaching here always carry the B flag: MOVE / MOVES
        exec_sreg_d   = hi == 4'hb ? n : sreg_q;
        exec_dreg_d   = hi == 4'h1 ? n : dreg_q;
        exec_move_d   = hi == 4'h1 || hi == 4'hb;
        exec_alt_d    = alt_q;
        exec_strobe_d = 1'b1;
        sreg_d        = 4'h0;
        dreg_d        = 4'h0;
        bflag_d       = 1'b0;
        alt_d         = 2'b00;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q        <= '0;
      dreg_q        <= '0;
      bflag_q       <= 1'b0;
      alt_q         <= '0;
      exec_sreg_q   <= '0;
      exec_dreg_q   <= '0;
      exec_alt_q    <= '0;
      exec_move_q   <= 1'b0;
      exec_strobe_q <= 1'b0;
      z_q           <= '0;
      zsel_q        <= '0;
      z_we_q        <= 1'b0;
      pc_wr_q       <= 1'b0;
    end else begin
      sreg_q        <= sreg_d;
      dreg_q        <= dreg_d;
      bflag_q       <= bflag_d;
      alt_q         <= alt_d;
      exec_sreg_q   <= exec_sreg_d;
      exec_dreg_q   <= exec_dreg_d;
      exec_alt_q    <= exec_alt_d;
      exec_move_q   <= exec_move_d;
      exec_strobe_q <= exec_strobe_d;
      z_q           <= z_d;
      zsel_q        <= zsel_d;
      z_we_q        <= z_we_d;
      pc_wr_q       <= pc_wr_d;
    end
  end
  assign sreg        = sreg_q;
  assign dreg        = dreg_q;
  assign bflag       = bflag_q;
  assign alt1        = alt_q[0];
  assign alt2        = alt_q[1];
  assign exec_sreg   = exec_sreg_q;
  assign exec_dreg   = exec_dreg_q;
  assign exec_alt    = exec_alt_q;
  assign exec_move   = exec_move_q;
  assign exec_strobe = exec_strobe_q;
  assign z           = z_q;
  assign zsel        = zsel_q;
  assign z_we        = z_we_q;
  assign pc_wr       = pc_wr_q;
endmodule

// File: tb/tb_fig_04a_block_075_prefix_regsel.sv
// tb_fig_04a_block_075_prefix_regsel: directed vector table plus randomized run against a rule-level model
module tb_fig_04a_block_075_prefix_regsel;
  logic clk = 1'b0, reset = 1'b1, op_valid = 1'b0, wb_valid = 1'b0;
  logic [7:0] opcode = '0;
  logic [15:0] wb_data = '0;
  logic [3:0] sreg, dreg, exec_sreg, exec_dreg, zsel;
  logic bflag, alt1, alt2, exec_move, exec_strobe, z_we, pc_wr;
  logic [1:0] exec_alt;
  logic [15:0] z;
  int n_cmp = 0, n_bad = 0;

  fig_04a_block_075_prefix_regsel #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode),
    .wb_valid(wb_valid), .wb_data(wb_data), .sreg(sreg), .dreg(dreg),
    .bflag(bflag), .alt1(alt1), .alt2(alt2), .exec_sreg(exec_sreg),
    .exec_dreg(exec_dreg), .exec_alt(exec_alt), .exec_move(exec_move),
    .exec_strobe(exec_strobe), .z(z), .zsel(zsel), .z_we(z_we), .pc_wr(pc_wr)
  );

  always #5 clk = ~clk;

  typedef logic [44:0] obs_t;
  typedef struct {
    logic rst, ov, wv;
    logic [7:0] op;
    logic [15:0] wd;
    obs_t exp;
  } vec_t;

  function automatic obs_t pk(logic [3:0] s, logic [3:0] d, logic b, logic [1:0] a,
                              logic [3:0] es, logic [3:0] ed, logic [1:0] ea, logic em,
                              logic st, logic [15:0] zz, logic [3:0] zs, logic we, logic pw);
    return {s, d, b, a, es, ed, ea, em, st, zz, zs, we, pw};
  endfunction

  function automatic vec_t mv(logic rst, logic ov, logic [7:0] op, logic wv, logic [15:0] wd, obs_t e);
    vec_t v;
    v.rst = rst; v.ov = ov; v.op = op; v.wv = wv; v.wd = wd; v.exp = e;
    return v;
  endfunction

  function automatic obs_t actual();
    return pk(sreg, dreg, bflag, {alt2, alt1}, exec_sreg, exec_dreg, exec_alt, exec_move,
              exec_strobe, z, zsel, z_we, pc_wr);
  endfunction

  task automatic check(string name, obs_t exp);
    obs_t act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic ov, logic [7:0] op, logic wv, logic [15:0] wd);
    reset = rst; op_valid = ov; opcode = op; wb_valid = wv; wb_data = wd;
  endtask

  // reference model: architectural state after each clock, derived from the prefix rules
  logic [3:0] m_s, m_d, m_es, m_ed, m_zs;
  logic [1:0] m_a, m_ea;
  logic m_b, m_em, m_st, m_we, m_pw;
  logic [15:0] m_z;

  task automatic model(logic rst, logic ov, logic [7:0] op, logic wv, logic [15:0] wd);
    logic [3:0] hi = op[7:4], lo = op[3:0];
    logic prefix;
    if (rst) begin
      {m_s, m_d, m_es, m_ed, m_zs, m_a, m_ea, m_b, m_em, m_st, m_we, m_pw, m_z} = '0;
      return;
    end
    m_we = wv;
    m_pw = wv && (m_ed == 15);
    if (wv) begin m_z = wd; m_zs = m_ed; end
    m_st = 1'b0;
    if (!ov) return;
    prefix = (op >= 8'h3d && op <= 8'h3f) || hi == 2 || (!m_b && (hi == 1 || hi == 11));
    if (prefix) begin
      if (op == 8'h3d) m_a = 2'd1;
      if (op == 8'h3e) m_a = 2'd2;
      if (op == 8'h3f) m_a = 2'd3;
      if (hi == 2) begin m_s = lo; m_d = lo; m_b = 1; end
      if (hi == 1 && !m_b) m_d = lo;
      if (hi == 11 && !m_b) m_s = lo;
    end else begin
      m_em = m_b && (hi == 1 || hi == 11);
      m_es = (m_em && hi == 11) ? lo : m_s;
      m_ed = (m_em && hi == 1) ? lo : m_d;
      m_ea = m_a;
      m_st = 1'b1;
      m_s = 0; m_d = 0; m_b = 0; m_a = 0;
    end
  endtask

  vec_t tbl[24];

  initial begin
    tbl[0]  = mv(1, 0, 8'h00, 0, 16'h0000, pk(0,0,0,0, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[1]  = mv(1, 1, 8'h2a, 0, 16'h0000, pk(0,0,0,0, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[2]  = mv(0, 1, 8'h3e, 0, 16'h0000, pk(0,0,0,2, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[3]  = mv(0, 1, 8'h2a, 0, 16'h0000, pk(10,10,1,2, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[4]  = mv(0, 1, 8'h50, 0, 16'h0000, pk(0,0,0,0, 10,10,2,0,1, 16'h0000,0,0,0));
    tbl[5]  = mv(0, 0, 8'h50, 0, 16'h0000, pk(0,0,0,0, 10,10,2,0,0, 16'h0000,0,0,0));
    tbl[6]  = mv(0, 1, 8'h13, 0, 16'h0000, pk(0,3,0,0, 10,10,2,0,0, 16'h0000,0,0,0));
    tbl[7]  = mv(0, 1, 8'hb5, 0, 16'h0000, pk(5,3,0,0, 10,10,2,0,0, 16'h0000,0,0,0));
    tbl[8]  = mv(0, 1, 8'h50, 0, 16'h0000, pk(0,0,0,0, 5,3,0,0,1, 16'h0000,0,0,0));
    tbl[9]  = mv(0, 0, 8'h00, 1, 16'hbeef, pk(0,0,0,0, 5,3,0,0,0, 16'hbeef,3,1,0));
    tbl[10] = mv(0, 1, 8'h24, 0, 16'h1111, pk(4,4,1,0, 5,3,0,0,0, 16'hbeef,3,0,0));
    tbl[11] = mv(0, 1, 8'h17, 0, 16'h0000, pk(0,0,0,0, 4,7,0,1,1, 16'hbeef,3,0,0));
    tbl[12] = mv(0, 1, 8'h22, 0, 16'h0000, pk(2,2,1,0, 4,7,0,1,0, 16'hbeef,3,0,0));
    tbl[13] = mv(0, 1, 8'hb9, 0, 16'h0000, pk(0,0,0,0, 9,2,0,1,1, 16'hbeef,3,0,0));
    tbl[14] = mv(0, 1, 8'h1f, 0, 16'h0000, pk(0,15,0,0, 9,2,0,1,0, 16'hbeef,3,0,0));
    tbl[15] = mv(0, 1, 8'h50, 0, 16'h0000, pk(0,0,0,0, 0,15,0,0,1, 16'hbeef,3,0,0));
    tbl[16] = mv(0, 1, 8'h50, 1, 16'h8000, pk(0,0,0,0, 0,0,0,0,1, 16'h8000,15,1,1));
    tbl[17] = mv(0, 0, 8'h00, 0, 16'h0000, pk(0,0,0,0, 0,0,0,0,0, 16'h8000,15,0,0));
    tbl[18] = mv(0, 1, 8'h2c, 0, 16'h0000, pk(12,12,1,0, 0,0,0,0,0, 16'h8000,15,0,0));
    tbl[19] = mv(1, 1, 8'h50, 1, 16'h1234, pk(0,0,0,0, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[20] = mv(0, 1, 8'h3d, 0, 16'h0000, pk(0,0,0,1, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[21] = mv(0, 1, 8'h3f, 0, 16'h0000, pk(0,0,0,3, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[22] = mv(0, 1, 8'h13, 0, 16'h0000, pk(0,3,0,3, 0,0,0,0,0, 16'h0000,0,0,0));
    tbl[23] = mv(0, 1, 8'h60, 1, 16'h0001, pk(0,0,0,0, 0,3,3,0,1, 16'h0001,0,1,0));

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].ov, tbl[i].op, tbl[i].wv, tbl[i].wd);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    drive(1, 0, 8'h00, 0, 16'h0000);
    model(1, 0, 8'h00, 0, 16'h0000);
    @(posedge clk); #1;
    check("rand_reset", pk(m_s, m_d, m_b, m_a, m_es, m_ed, m_ea, m_em, m_st, m_z, m_zs, m_we, m_pw));
    for (int i = 0; i < 600; i++) begin
      logic r, ov, wv;
      logic [7:0] op;
      logic [15:0] wd;
      logic [3:0] his[4] = '{4'h1, 4'h2, 4'hb, 4'h3};
      r  = ($urandom_range(0, 49) == 0);
      ov = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 2) == 0);
      wd = 16'($urandom);
      op = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        op[7:4] = his[$urandom_range(0, 3)];
        if (op[7:4] == 4'h3) op[3:0] = 4'($urandom_range(13, 15));
      end
      drive(r, ov, op, wv, wd);
      model(r, ov, op, wv, wd);
      @(posedge clk); #1;
      check($sformatf("rand%0d", i), pk(m_s, m_d, m_b, m_a, m_es, m_ed, m_ea, m_em, m_st, m_z, m_zs, m_we, m_pw));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
